algo_processor: RTL and testbench
=================================

Name: algo_processor

Overview:
- Small byte-processing controller holding a 256x8 data memory, an 8-bit pointer and an algorithm select.
- Configured through a 3-bit command input (btn) and an 8-bit operand (bytePos).
- On a run command it scans COUNT bytes from the pointer, computing either the sum or the maximum.
- Drives two active-low 7-segment digits (hex1 = high nibble, hex2 = low nibble) as the top-level board block.

Parameters:
- COUNT, 16, number of bytes scanned per run (legal range 1..256).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- bytePos  input  8  operand: pointer load value or write data.
- btn  input  3  command code.
- hex1  output  7  7-seg pattern for the high nibble of the display byte.
- hex2  output  7  7-seg pattern for the low nibble of the display byte.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears ptr=0, alg=0, state=IDLE, result=0, disp=0x00, btn_q=0.
  - hex1 = hex2 = 7'b1000000.
  - Memory contents are not reset.
- Command accept: btn is registered into btn_q every cycle. A command is accepted on an edge where btn != 0 and btn != btn_q.
  - Holding a code executes it exactly once.
  - Changing directly from one nonzero code to another (e.g. 011 to 110) is accepted.
- Commands in IDLE or DONE (state becomes IDLE except for 111):
  - 001: ptr+1, 255 wraps to 0.
  - 010: ptr-1, 0 wraps to 255.
  - 011: ptr=bytePos.
  - 100: mem[ptr]=bytePos.
  - 101: alg=0 (sum).
  - 110: alg=1 (max).
  - 111: start run.
- In RUN, all commands are ignored, but btn_q still tracks btn.
- Run:
  - Scans addresses ptr, ptr+1, ..., ptr+COUNT-1, wrapping mod 256.
  - Synchronous memory read, one byte per cycle.
  - alg=0: result = 8-bit sum, mod 256.
  - alg=1: result = unsigned maximum.
  - The accumulator clears at run start.
  - DONE is entered exactly COUNT+1 cycles after the accept edge.
  - ptr and alg are unchanged by a run.
- Display register disp, updated every cycle:
  - IDLE: disp = mem[ptr], one cycle of read latency.
  - RUN: disp = 0x00 and both hex outputs show 7'b0111111 (dash).
  - DONE: disp = result.
- Reset asserted mid-run aborts to IDLE with the reset values above.
- 7-seg encoding, active-low, bit6..bit0 = g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Optional Feature:
- Macro PTR_LED_EN.
- When defined, adds output port ptr_led (output, 8 bits), mirroring ptr combinationally; it is 0 in reset.
- When undefined, the port does not exist and behaviour is otherwise identical.

Decomposition:
- Package processor_pkg holds:
  - command codes CMD_NEXT..CMD_RUN;
  - state enum IDLE/RUN/DONE;
  - constant SEG_DASH = 7'b0111111.
- One sub-module, hex_to_7seg (4-bit input to 7-bit active-low pattern), instantiated twice.

Test Plan:
- Reset: rst=0 for 3 cycles -> hex1=hex2=7'b1000000. Release, btn=0 -> no state change.
- Load and write: btn=011 with bytePos=10 -> ptr=10. btn=000, then btn=100 with bytePos=0x3C -> next cycles show hex1=0110000, hex2=1000110.
- Wrap: ptr=255, btn=001 -> ptr=0. btn=000, then btn=010 -> ptr=255. Holding 001 for 5 cycles increments once.
- Sum (COUNT=4): write 10,20,30,40 at addresses 10..13, ptr=10, btn=101 then 111 -> DONE after 5 cycles; display 0x64, hex1=0000010, hex2=0011001.
- Max and mid-run reset:
  - Same data, btn=110 directly followed by 111 (no 000 between) -> display 0x28, hex1=0100100, hex2=0000000.
  - Repeat the run and drop rst during RUN -> IDLE, display 00.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the algo_processor byte-processing controller:
// command codes, controller states, algorithm select and display constants.
package processor_pkg;

  // Command codes presented on btn
  localparam logic [2:0] CMD_NEXT  = 3'b001;
  localparam logic [2:0] CMD_PREV  = 3'b010;
  localparam logic [2:0] CMD_LOAD  = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_SUM   = 3'b101;
  localparam logic [2:0] CMD_MAX   = 3'b110;
  localparam logic [2:0] CMD_RUN   = 3'b111;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Algorithm select
  typedef enum logic {
    ALG_SUM = 1'b0,
    ALG_MAX = 1'b1
  } alg_t;

  // Active-low pattern with only segment g lit
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // One accumulation step of the selected algorithm
  function automatic logic [7:0] alg_step(input alg_t alg,
                                          input logic [7:0] acc,
                                          input logic [7:0] data);
    if (alg == ALG_MAX) begin
      return (data > acc) ? data : acc;
    end
    return acc + data;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern, bit6..bit0 = g..a.
module hex_to_7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Pure lookup of the glyph for each hex digit
  always_comb begin
    o_seg = 7'b1111111;
    case (i_nibble)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/algo_processor.sv
// algo_processor: 256x8 data memory with a pointer, edge-triggered command
// interface and a run engine that sums or maximises COUNT bytes starting at
// the pointer. The display byte drives two active-low 7-segment digits.
// Optional macro PTR_LED_EN adds output ptr_led mirroring the pointer.
module algo_processor
  import processor_pkg::*;
#(
  parameter int COUNT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bytePos,
  input  logic [2:0] btn,
  output logic [6:0] hex1,
  output logic [6:0] hex2
`ifdef PTR_LED_EN
  ,
  output logic [7:0] ptr_led
`endif
);

  // Run counter must hold values 0..COUNT inclusive
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

  logic [7:0]       mem [256];
  logic [7:0]       r_rd_data;

  logic [2:0]       r_btn_q;
  state_t           r_state;
  alg_t             r_alg;
  logic [7:0]       r_ptr;
  logic [7:0]       r_scan_addr;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_acc;
  logic [7:0]       r_result;
  logic [7:0]       r_disp;

  logic             w_accept;
  logic             w_cmd_ok;
  logic             w_mem_we;
  logic [6:0]       w_seg_hi;
  logic [6:0]       w_seg_lo;

  // A command fires on the first cycle a nonzero code differs from last cycle
  assign w_accept = (btn != 3'b000) && (btn != r_btn_q);
  assign w_cmd_ok = w_accept && (r_state != RUN);
  assign w_mem_we = w_cmd_ok && (btn == CMD_WRITE);

  // Data memory: write port at the pointer, registered read at the scan address
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[r_ptr] <= bytePos;
    end
    r_rd_data <= mem[r_scan_addr];
  end

  // Control FSM: command decode in IDLE/DONE, byte-per-cycle scan in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_q     <= 3'b000;
      r_state     <= IDLE;
      r_alg       <= ALG_SUM;
      r_ptr       <= 8'h00;
      r_scan_addr <= 8'h00;
      r_cnt       <= '0;
      r_acc       <= 8'h00;
      r_result    <= 8'h00;
    end else begin
      r_btn_q <= btn;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state <= IDLE;
            case (btn)
              CMD_NEXT: r_ptr <= r_ptr + 8'd1;
              CMD_PREV: r_ptr <= r_ptr - 8'd1;
              CMD_LOAD: r_ptr <= bytePos;
              CMD_SUM:  r_alg <= ALG_SUM;
              CMD_MAX:  r_alg <= ALG_MAX;
              CMD_RUN: begin
                r_state     <= RUN;
                r_scan_addr <= r_ptr;
                r_cnt       <= '0;
                r_acc       <= 8'h00;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          // Cycle k issues read k (k < COUNT) and folds in the byte read at k-1
          if (r_cnt < CNT_LAST) begin
            r_scan_addr <= r_scan_addr + 8'd1;
          end
          if (r_cnt != '0) begin
            r_acc <= alg_step(r_alg, r_acc, r_rd_data);
          end
          if (r_cnt == CNT_LAST) begin
            r_result <= alg_step(r_alg, r_acc, r_rd_data);
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Display byte: memory at the pointer when idle, blank while running, result when done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp <= 8'h00;
    end else begin
      case (r_state)
        RUN:     r_disp <= 8'h00;
        DONE:    r_disp <= r_result;
        default: r_disp <= mem[r_ptr];
      endcase
    end
  end

  hex_to_7seg u_seg_hi (
    .i_nibble (r_disp[7:4]),
    .o_seg    (w_seg_hi)
  );

  hex_to_7seg u_seg_lo (
    .i_nibble (r_disp[3:0]),
    .o_seg    (w_seg_lo)
  );

  // Both digits show a dash for the whole run
  assign hex1 = (r_state == RUN) ? SEG_DASH : w_seg_hi;
  assign hex2 = (r_state == RUN) ? SEG_DASH : w_seg_lo;

`ifdef PTR_LED_EN
  assign ptr_led = r_ptr;
`endif

endmodule

// File: tb/tb_algo_processor.sv
// Self-checking bench for algo_processor with COUNT=4. A behavioural model
// (memory array, pointer, algorithm flag) predicts the displayed byte after
// each command and the run result computed directly from the memory contents.
module tb_algo_processor;
  import processor_pkg::*;

  localparam int COUNT = 4;

  logic       clk;
  logic       rst;
  logic [7:0] bytePos;
  logic [2:0] btn;
  logic [6:0] hex1;
  logic [6:0] hex2;
`ifdef PTR_LED_EN
  logic [7:0] ptr_led;
`endif

  algo_processor #(.COUNT(COUNT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bytePos (bytePos),
    .btn     (btn),
    .hex1    (hex1),
    .hex2    (hex2)
`ifdef PTR_LED_EN
    ,
    .ptr_led (ptr_led)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  bit   [7:0] m_ptr;
  bit         m_alg;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7:0] model_run();
    logic [7:0] r;
    logic [7:0] v;
    bit   [7:0] a;
    r = 8'h00;
    for (int i = 0; i < COUNT; i++) begin
      a = m_ptr + 8'(i);
      v = m_mem[a];
      if (m_alg) r = (v > r) ? v : r;
      else       r = r + v;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [7:0] val);
    check(tag, {18'd0, hex1, hex2}, {18'd0, seg(val[7:4]), seg(val[3:0])});
  endtask

  // Issue a command (entered at a negedge), hold it for 'hold' edges, release, check display
  task automatic simple_cmd(input logic [2:0] code, input logic [7:0] op,
                            input int hold, input bit chk);
    btn = code;
    bytePos = op;
    repeat (hold) @(negedge clk);
    btn = 3'b000;
    case (code)
      CMD_NEXT:  m_ptr = m_ptr + 8'd1;
      CMD_PREV:  m_ptr = m_ptr - 8'd1;
      CMD_LOAD:  m_ptr = op;
      CMD_WRITE: m_mem[m_ptr] = op;
      CMD_SUM:   m_alg = 1'b0;
      CMD_MAX:   m_alg = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    $display("cmd %b op %02h hold %0d -> ptr %02h alg %0d", code, op, hold, m_ptr, m_alg);
    if (chk) check_disp("idle_disp", m_mem[m_ptr]);
  endtask

  // Start a run (entered at a negedge) and follow it to the displayed result
  task automatic run_cmd(input bit noise);
    int dash;
    logic [7:0] exp;
    exp = model_run();
    btn = CMD_RUN;
    dash = 0;
    for (int g = 0; g < COUNT + 20; g++) begin
      @(negedge clk);
      if (hex1 == SEG_DASH && hex2 == SEG_DASH) dash++;
      else break;
      btn = noise ? 3'($urandom_range(0, 7)) : 3'b000;
    end
    btn = 3'b000;
    check("run_len", dash, COUNT + 1);
    check_disp("run_gap", 8'h00);
    @(negedge clk);
    $display("run ptr %02h alg %0d -> expect %02h", m_ptr, m_alg, exp);
    check_disp("run_result", exp);
  endtask

  initial begin
    int op;
    rst = 1'b0;
    btn = 3'b000;
    bytePos = 8'h00;
    m_ptr = 8'h00;
    m_alg = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check("reset_hex1", {25'd0, hex1}, {25'd0, 7'b1000000});
    check("reset_hex2", {25'd0, hex2}, {25'd0, 7'b1000000});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Fill the whole memory; pointer wraps back to 0 afterwards
    for (int a = 0; a < 256; a++) begin
      simple_cmd(CMD_WRITE, 8'($urandom_range(0, 255)), 1, 1'b1);
      simple_cmd(CMD_NEXT, 8'h00, 1, 1'b0);
    end
    check_disp("fill_wrap", m_mem[0]);

    // Load and write
    simple_cmd(CMD_LOAD, 8'd10, 1, 1'b1);
    simple_cmd(CMD_WRITE, 8'h3C, 1, 1'b1);
    check("w3c_hex", {18'd0, hex1, hex2}, {18'd0, 7'b0110000, 7'b1000110});

    // Pointer wrap and hold-once
    simple_cmd(CMD_LOAD, 8'd255, 1, 1'b1);
    simple_cmd(CMD_NEXT, 8'h00, 1, 1'b1);
    simple_cmd(CMD_PREV, 8'h00, 1, 1'b1);
    simple_cmd(CMD_NEXT, 8'h00, 5, 1'b1);

    // Sum of 10,20,30,40
    simple_cmd(CMD_LOAD, 8'd10, 1, 1'b1);
    simple_cmd(CMD_WRITE, 8'd10, 1, 1'b1);
    simple_cmd(CMD_NEXT, 8'h00, 1, 1'b1);
    simple_cmd(CMD_WRITE, 8'd20, 1, 1'b1);
    simple_cmd(CMD_NEXT, 8'h00, 1, 1'b1);
    simple_cmd(CMD_WRITE, 8'd30, 1, 1'b1);
    simple_cmd(CMD_NEXT, 8'h00, 1, 1'b1);
    simple_cmd(CMD_WRITE, 8'd40, 1, 1'b1);
    simple_cmd(CMD_LOAD, 8'd10, 1, 1'b1);
    simple_cmd(CMD_SUM, 8'h00, 1, 1'b1);
    run_cmd(1'b0);
    check("sum_hex", {18'd0, hex1, hex2}, {18'd0, 7'b0000010, 7'b0011001});

    // Max selected and run started back-to-back without a release
    btn = CMD_MAX;
    @(negedge clk);
    m_alg = 1'b1;
    run_cmd(1'b1);
    check("max_hex", {18'd0, hex1, hex2}, {18'd0, 7'b0100100, 7'b0000000});
    simple_cmd(CMD_NEXT, 8'h00, 1, 1'b1);

    // Randomised command mix
    for (int t = 0; t < 200; t++) begin
      op = $urandom_range(0, 7);
      if (op < 6) begin
        simple_cmd(3'(op + 1), 8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'b1);
      end else if (op == 6) begin
        run_cmd(1'($urandom_range(0, 1)));
      end else begin
        btn = ($urandom_range(0, 1) != 0) ? CMD_MAX : CMD_SUM;
        m_alg = (btn == CMD_MAX);
        @(negedge clk);
        run_cmd(1'b0);
      end
    end

    // Reset asserted in the middle of a run
    simple_cmd(CMD_LOAD, 8'd250, 1, 1'b1);
    btn = CMD_RUN;
    @(negedge clk);
    btn = 3'b000;
    @(negedge clk);
    check("midrun_dash", {25'd0, hex1}, {25'd0, SEG_DASH});
    rst = 1'b0;
    #1;
    check_disp("midrun_reset", 8'h00);
    m_ptr = 8'h00;
    m_alg = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_disp("post_reset", m_mem[0]);
    simple_cmd(CMD_PREV, 8'h00, 1, 1'b1);
    run_cmd(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
